// File: rtl/rainbow_pwm.sv
// rainbow_pwm: phase-shifted triangle-wave PWM on CHANNELS active-low LEDs.
// Define RAINBOW_PWM_DEBOUNCE_EN to enable the per-button debounce counters.
module rainbow_pwm #(
  parameter int CHANNELS        = 3,
  parameter int PWM_WIDTH       = 8,
  parameter int STEP_CYCLES     = 48000,
  parameter int DEBOUNCE_CYCLES = 120000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                button_a,
  input  logic                button_b,
  output logic [CHANNELS-1:0] led,
  output logic [1:0]          mode
);

  localparam int W  = PWM_WIDTH;
  localparam int PW = PWM_WIDTH + 1;
  localparam int SW = $clog2(STEP_CYCLES + 1);

  if (CHANNELS < 1 || PWM_WIDTH < 2 || STEP_CYCLES < 8 ||
      DEBOUNCE_CYCLES < 1) begin : g_bad_params
    $error("rainbow_pwm: parameter out of range");
  end

  typedef enum logic [1:0] {
    M_RAINBOW = 2'd0,
    M_BREATHE = 2'd1,
    M_STATIC  = 2'd2,
    M_OFF     = 2'd3
  } mode_e;

  logic [1:0] pin;
  logic [1:0] s1;
  logic [1:0] s2;
  logic [1:0] deb;
  logic [1:0] deb_q;
  logic [1:0] press;

  assign pin = {button_b, button_a};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '1;
      s2 <= '1;
    end else begin
      s1 <= pin;
      s2 <= s1;
    end
  end

`ifdef RAINBOW_PWM_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [DW-1:0] dcnt [2];

  // a level is accepted only after it differs for the full window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb <= '1;
      for (int i = 0; i < 2; i++) dcnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (s2[i] != deb[i]) begin
          if (dcnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
            deb[i]  <= s2[i];
            dcnt[i] <= '0;
          end else begin
            dcnt[i] <= dcnt[i] + 1'b1;
          end
        end else begin
          dcnt[i] <= '0;
        end
      end
    end
  end
`else
  assign deb = s2;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) deb_q <= '1;
    else     deb_q <= deb;
  end

  assign press = deb_q & ~deb;

  mode_e mode_q;
  mode_e mode_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mode_q <= M_RAINBOW;
    else     mode_q <= mode_d;
  end

  always_comb begin
    mode_d = mode_q;
    if (press[0]) begin
      unique case (mode_q)
        M_RAINBOW: mode_d = M_BREATHE;
        M_BREATHE: mode_d = M_STATIC;
        M_STATIC:  mode_d = M_OFF;
        M_OFF:     mode_d = M_RAINBOW;
        default:   mode_d = M_RAINBOW;
      endcase
    end
  end

  assign mode = mode_q;

  logic [1:0]    speed_q;
  logic [SW-1:0] period;
  logic [SW-1:0] scnt;
  logic          tick;
  logic          run_en;
  logic [PW-1:0] phase;
  logic [W-1:0]  pcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) speed_q <= '0;
    else     speed_q <= speed_q + {1'b0, press[1]};
  end

  always_comb begin
    period = SW'(STEP_CYCLES);
    unique case (speed_q)
      2'd0: period = SW'(STEP_CYCLES);
      2'd1: period = SW'(STEP_CYCLES >> 1);
      2'd2: period = SW'(STEP_CYCLES >> 2);
      2'd3: period = SW'(STEP_CYCLES >> 3);
      default: period = SW'(STEP_CYCLES);
    endcase
  end

  assign tick   = (scnt == period - 1'b1);
  assign run_en = (mode_q == M_RAINBOW) || (mode_q == M_BREATHE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scnt  <= '0;
      phase <= '0;
      pcnt  <= '0;
    end else begin
      scnt <= (tick || press[1]) ? '0 : scnt + 1'b1;
      if (tick && run_en) phase <= phase + 1'b1;
      pcnt <= pcnt + 1'b1;
    end
  end

  function automatic logic [W-1:0] tri_wave(input logic [PW-1:0] p);
    return p[W] ? ~p[W-1:0] : p[W-1:0];
  endfunction

  logic [CHANNELS-1:0] lit;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    localparam logic [PW-1:0] OFS = PW'((k * (2 ** PW)) / CHANNELS);
    logic [PW-1:0] shifted;
    logic [W-1:0]  target;
    logic [W-1:0]  duty;

    assign shifted = phase + OFS;

    always_comb begin
      target = '0;
      unique case (1'b1)
        (mode_q == M_RAINBOW),
        (mode_q == M_STATIC):  target = tri_wave(shifted);
        (mode_q == M_BREATHE): target = tri_wave(phase);
        default:               target = '0;
      endcase
    end

    // duty only changes at the period boundary to avoid runt pulses
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                   duty <= '0;
      else if (pcnt == '1)       duty <= target;
    end

    assign lit[k] = (pcnt < duty);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) led <= '1;
    else     led <= ~lit;
  end

endmodule
